trng_sampler: RTL and testbench
===============================

# trng_sampler

Digital back end for the 32-way multi-ring-oscillator entropy source. Synchronises the free-running ring-oscillator outputs into the system clock domain, XOR-compresses them to one raw bit per cycle, and debiases with a von Neumann corrector. Packs corrected bits into words offered on a valid/ready port, and runs a repetition-count health check on the raw stream.

## Interface
Parameters:
- N_RO, 32, number of ring-oscillator inputs
- WORD_W, 32, output word width (≥2)
- SYNC_STAGES, 2, synchroniser flops per RO input (≥2)
- STUCK_LIMIT, 64, consecutive identical raw bits that flag a failure (≥2, ≤ 2^16-1)

Ports:
- CLK  input  1  system clock
- RESET  input  1  asynchronous, active-high reset; clears every flop
- EN  input  1  sampling enable
- RO_IN  input  N_RO  asynchronous ring-oscillator outputs
- WORD_O  output  WORD_W  corrected random word
- VALID_O  output  1  WORD_O holds a complete word
- READY_I  input  1  consumer accepts WORD_O
- RAW_O  output  1  registered XOR of the synchronised RO bits (debug tap)
- STUCK_O  output  1  repetition-count health failure, sticky until RESET

## Operation
- Each RO_IN bit passes through its own SYNC_STAGES-flop synchroniser. The synchroniser flops run regardless of EN.
- Raw bit = XOR of all synchronised bits, registered into RAW_O.
- Von Neumann FSM, two states:
  - FIRST: latch RAW_O as held bit, go to SECOND.
  - SECOND: compare RAW_O with the held bit.
    - pair 01 → emit 0
    - pair 10 → emit 1
    - pair 00/11 → emit nothing
    - in all cases go to FIRST.
- The FSM advances only when EN=1. EN=0 forces FIRST and discards any held bit.
- Packer:
  - Emitted bits shift into the word register at LSB; earlier bits move toward MSB, so the first bit of a word ends in WORD_O[WORD_W-1].
  - A bit counter of width clog2(WORD_W)+1 counts the bits.
  - When the WORD_W-th bit is shifted in, VALID_O sets.
- Handshake:
  - Transfer occurs on an edge with VALID_O=1 and READY_I=1. On that edge VALID_O clears and the counter resets.
  - A bit emitted on the same edge becomes bit 1 of the next word (counter=1); no loss.
  - While VALID_O=1 and READY_I=0, WORD_O is frozen and emitted bits are dropped. The FSM keeps pairing.
  - READY_I while VALID_O=0 has no effect.
- EN=0 retains a partial word and any pending valid word; the handshake still completes.
- Health check:
  - A run counter counts consecutive equal RAW_O values. It restarts at 1 on any change.
  - STUCK_O sets when the counter reaches STUCK_LIMIT. The counter then saturates.
  - Runs only when EN=1. EN=0 resets the counter to 0, but STUCK_O is not cleared.
  - STUCK_O does not gate output. The consumer decides.
- Reset values: WORD_O=0, VALID_O=0, RAW_O=0, STUCK_O=0; FSM=FIRST; all counters 0.

## Timing
- An RO_IN change reaches RAW_O SYNC_STAGES+1 edges later (3 by default).
- A corrected bit is emitted on the edge that registers the FSM's SECOND-state decision. It is shifted into the word register on that same edge.
- VALID_O is registered. It is high the cycle after the edge that shifts in bit WORD_W.
- Minimum spacing between words: 2·WORD_W cycles, since each bit needs one pair.
- RESET asserted mid-word or mid-handshake discards all state immediately. The first sample after deassertion starts in FIRST.
- No combinational path from READY_I or RO_IN to any output.

## Structure
- Package trng_pkg holds:
  - vn_state_t enum (FIRST, SECOND)
  - default constants for N_RO, WORD_W, STUCK_LIMIT
- Sub-module von_neumann_corrector contains:
  - inputs CLK, RESET, EN, raw bit
  - outputs bit and bit_valid
  - the two-state FSM
- The top level holds the synchronisers, the XOR, the packer/handshake and the health counter.

## Test plan
All scenarios below use WORD_W=8 and STUCK_LIMIT=8, with RO_IN driven synchronously.

- Raw pairs 01,10,01,10,… (8 pairs), READY_I=1 → one word 8'h55 with VALID_O for one cycle, 16 cycles after the first pair's raw bit.
- Raw stream 00,11 repeated for 20 cycles → VALID_O never rises. STUCK_O stays 0 because alternation breaks the runs at 2.
- Hold RO_IN constant with EN=1 → STUCK_O rises on the 8th identical RAW_O, remains 1 after RO_IN toggles, and clears only on RESET.
- Complete word 8'hFF (pairs 10×8), then READY_I=0 for 20 cycles while 10-pairs continue → WORD_O stays 8'hFF. After READY_I=1 the next word starts empty, because the stalled bits were dropped.
- Handshake edge coinciding with an emitted bit → the next word's bit count starts at 1. That bit appears in WORD_O[7] of the following word.
- RESET pulse after 4 of 8 bits, and a second pulse during VALID_O=1 → all outputs read 0 next cycle, and a full 8 new bits are required for VALID_O. Also, EN=0 between the two bits of a pair discards the held bit.

Source files
------------

// File: rtl/trng_pkg.sv
// Shared types and default sizing for the ring-oscillator TRNG back end.
package trng_pkg;

  typedef enum logic {
    FIRST  = 1'b0,
    SECOND = 1'b1
  } vn_state_t;

  localparam int N_RO_DEF        = 32;
  localparam int WORD_W_DEF      = 32;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int STUCK_LIMIT_DEF = 64;

endpackage

// File: rtl/von_neumann_corrector.sv
// Von Neumann debiaser: pairs consecutive raw bits, emits 0 for 01 and 1 for 10.
module von_neumann_corrector
  import trng_pkg::*;
(
  input  logic CLK,
  input  logic RESET,
  input  logic EN,
  input  logic raw,
  output logic vn_bit,
  output logic bit_valid
);

  vn_state_t state, state_nxt;
  logic      held, held_nxt;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= FIRST;
      held  <= 1'b0;
    end else begin
      state <= state_nxt;
      held  <= held_nxt;
    end
  end

  // Dropping EN falls back to FIRST, so a half-collected pair is thrown away.
  always_comb begin
    state_nxt = FIRST;
    held_nxt  = held;
    vn_bit    = held;
    bit_valid = 1'b0;
    if (EN) begin
      case (state)
        FIRST: begin
          held_nxt  = raw;
          state_nxt = SECOND;
        end
        SECOND: begin
          bit_valid = (raw != held);
          state_nxt = FIRST;
        end
        default: state_nxt = FIRST;
      endcase
    end
  end

endmodule

// File: rtl/trng_sampler.sv
// Multi-RO entropy back end: synchronise, XOR-compress, debias, pack into words
// on a valid/ready port, and flag stuck raw streams with a repetition count.
module trng_sampler
  import trng_pkg::*;
#(
  parameter int N_RO        = N_RO_DEF,
  parameter int WORD_W      = WORD_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int STUCK_LIMIT = STUCK_LIMIT_DEF
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              EN,
  input  logic [N_RO-1:0]   RO_IN,
  output logic [WORD_W-1:0] WORD_O,
  output logic              VALID_O,
  input  logic              READY_I,
  output logic              RAW_O,
  output logic              STUCK_O
);

  localparam int CNT_W = $clog2(WORD_W) + 1;
  localparam int RUN_W = 16;
  localparam logic [RUN_W-1:0] RUN_LIM = RUN_W'(STUCK_LIMIT);

  logic [SYNC_STAGES-1:0][N_RO-1:0] sync_q;
  logic                             vn_bit, bit_valid;
  logic [CNT_W-1:0]                 bit_cnt;
  logic [RUN_W-1:0]                 run_cnt, run_nxt;
  logic                             prev_raw;

  // Stage 0 captures RO_IN; the deepest stage feeds the XOR tree.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sync_q <= '0;
      RAW_O  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], RO_IN};
      RAW_O  <= ^sync_q[SYNC_STAGES-1];
    end
  end

  von_neumann_corrector u_vn (
    .CLK      (CLK),
    .RESET    (RESET),
    .EN       (EN),
    .raw      (RAW_O),
    .vn_bit   (vn_bit),
    .bit_valid(bit_valid)
  );

  // A bit landing on the handshake edge opens the next word instead of being lost.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      WORD_O  <= '0;
      VALID_O <= 1'b0;
      bit_cnt <= '0;
    end else if (VALID_O) begin
      if (READY_I) begin
        VALID_O <= 1'b0;
        bit_cnt <= CNT_W'(bit_valid);
        if (bit_valid) WORD_O <= {WORD_O[WORD_W-2:0], vn_bit};
      end
    end else if (bit_valid) begin
      WORD_O  <= {WORD_O[WORD_W-2:0], vn_bit};
      bit_cnt <= bit_cnt + CNT_W'(1);
      if (bit_cnt == CNT_W'(WORD_W - 1)) VALID_O <= 1'b1;
    end
  end

  always_comb begin
    run_nxt = '0;
    if (EN) begin
      if (run_cnt == '0 || RAW_O != prev_raw) run_nxt = RUN_W'(1);
      else if (run_cnt < RUN_LIM)             run_nxt = run_cnt + RUN_W'(1);
      else                                    run_nxt = run_cnt;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      run_cnt  <= '0;
      prev_raw <= 1'b0;
      STUCK_O  <= 1'b0;
    end else begin
      run_cnt  <= run_nxt;
      prev_raw <= RAW_O;
      if (run_nxt == RUN_LIM) STUCK_O <= 1'b1;
    end
  end

endmodule

// File: tb/tb_trng_sampler.sv
// Self-checking bench for trng_sampler (WORD_W=8, STUCK_LIMIT=8) with a queue-based model.
module tb_trng_sampler;
  localparam int NRO = 32;
  localparam int W   = 8;
  localparam int LIM = 8;

  logic           CLK = 1'b0, RESET = 1'b0, EN = 1'b0, READY_I = 1'b0;
  logic [NRO-1:0] RO_IN = '0;
  logic [W-1:0]   WORD_O;
  logic           VALID_O, RAW_O, STUCK_O;

  always #5 CLK = ~CLK;

  trng_sampler #(.N_RO(NRO), .WORD_W(W), .SYNC_STAGES(2), .STUCK_LIMIT(LIM)) dut (
    .CLK(CLK), .RESET(RESET), .EN(EN), .RO_IN(RO_IN), .WORD_O(WORD_O),
    .VALID_O(VALID_O), .READY_I(READY_I), .RAW_O(RAW_O), .STUCK_O(STUCK_O)
  );

  int total = 0, bad = 0;

  // reference model state
  bit       m_sync[$];
  bit       m_raw, m_valid, m_prev, m_stuck;
  int       m_held, m_run;
  bit       m_bits[$];
  logic [7:0] m_word;

  // per-sample stream stimulus and observations
  bit sq[$], eq[$], rq[$];
  bit ov[$], os[$];
  logic [7:0] ow[$];

  typedef struct {
    string      name;
    logic [3:0] pat;
    int         len;
    bit         rdy;
    int         vcnt;
    int         first;
    logic [7:0] word;
    bit         stuck;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_sync = '{0, 0};
    m_raw = 0; m_valid = 0; m_prev = 0; m_stuck = 0;
    m_held = -1; m_run = 0; m_bits.delete(); m_word = '0;
  endtask

  task automatic model_step(input bit r, input bit en, input bit rdy, input bit rs);
    bit emit, eb;
    logic [7:0] w;
    if (rs) begin model_reset(); return; end
    emit = 0; eb = 0;
    if (!en) m_held = -1;
    else if (m_held < 0) m_held = m_raw;
    else begin
      if (m_held != int'(m_raw)) begin emit = 1; eb = m_held[0]; end
      m_held = -1;
    end
    if (m_valid && rdy) begin
      m_valid = 0; m_bits.delete();
      if (emit) m_bits.push_back(eb);
    end else if (!m_valid && emit) begin
      m_bits.push_back(eb);
      if (m_bits.size() == W) begin
        w = '0;
        foreach (m_bits[i]) w = {w[6:0], m_bits[i]};
        m_word = w; m_valid = 1; m_bits.delete();
      end
    end
    if (en) begin
      if (m_run == 0 || m_raw != m_prev) m_run = 1;
      else if (m_run < LIM) m_run++;
      if (m_run == LIM) m_stuck = 1;
    end else m_run = 0;
    m_prev = m_raw;
    m_raw = m_sync.pop_front();
    m_sync.push_back(r);
  endtask

  // One clock: drive RO_IN with parity r, advance model, compare #1 after the edge.
  task automatic cyc(input bit r, input bit en, input bit rdy, input bit rs);
    logic [NRO-1:0] v;
    v = NRO'($urandom);
    v[0] = v[0] ^ (^v) ^ r;
    RO_IN = v; EN = en; READY_I = rdy; RESET = rs;
    @(posedge CLK);
    model_step(r, en, rdy, rs);
    #1;
    chk("valid", VALID_O, m_valid);
    chk("raw", RAW_O, m_raw);
    chk("stuck", STUCK_O, m_stuck);
    if (m_valid) chk("word", WORD_O, m_word);
  endtask

  task automatic rst();
    cyc(1'($urandom), 0, 0, 1);
    chk("rst_word", WORD_O, 0);
    chk("rst_valid", VALID_O, 0);
    chk("rst_stuck", STUCK_O, 0);
    chk("rst_raw", RAW_O, 0);
  endtask

  task automatic clr();
    sq.delete(); eq.delete(); rq.delete();
  endtask

  task automatic add_pairs(input bit a, input bit b, input int n, input bit rdy);
    for (int i = 0; i < n; i++) begin
      sq.push_back(a); sq.push_back(b);
      eq.push_back(1); eq.push_back(1);
      rq.push_back(rdy); rq.push_back(rdy);
    end
  endtask

  // Stream bit k is the RAW_O value sampled on EN-cycle k (3-cycle EN=0 pipeline fill first).
  task automatic run_stream();
    bit r, en, rd;
    ov.delete(); ow.delete(); os.delete();
    for (int c = 0; c < sq.size() + 3; c++) begin
      r  = (c < sq.size()) ? sq[c] : 1'($urandom);
      en = (c >= 3) ? eq[c-3] : 1'b0;
      rd = (c >= 3) ? rq[c-3] : 1'b0;
      cyc(r, en, rd, 0);
      if (c >= 3) begin ov.push_back(VALID_O); ow.push_back(WORD_O); os.push_back(STUCK_O); end
    end
  endtask

  function automatic int first_valid();
    foreach (ov[i]) if (ov[i]) return i + 1;
    return 0;
  endfunction

  function automatic int vcount();
    int n = 0;
    foreach (ov[i]) if (ov[i]) n++;
    return n;
  endfunction

  initial begin
    bit pr;
    model_reset();
    tbl[0] = '{"alt55",    4'b0110, 18, 1, 1,  16, 8'h55, 0};
    tbl[1] = '{"pair0011", 4'b0011, 20, 1, 0,  0,  8'h00, 0};
    tbl[2] = '{"run7",     4'b1111, 7,  1, 0,  0,  8'h00, 0};
    tbl[3] = '{"run8",     4'b1111, 8,  1, 0,  0,  8'h00, 1};
    tbl[4] = '{"stallFF",  4'b1010, 36, 0, 21, 16, 8'hFF, 0};
    tbl[5] = '{"twoFF",    4'b1010, 34, 1, 2,  16, 8'hFF, 0};

    foreach (tbl[t]) begin
      rst(); clr();
      for (int i = 0; i < tbl[t].len; i++) begin
        sq.push_back(tbl[t].pat[3 - (i % 4)]); eq.push_back(1); rq.push_back(tbl[t].rdy);
      end
      run_stream();
      chk({tbl[t].name, "_vcnt"}, vcount(), tbl[t].vcnt);
      chk({tbl[t].name, "_first"}, first_valid(), tbl[t].first);
      if (tbl[t].first > 0) chk({tbl[t].name, "_word"}, ow[tbl[t].first-1], tbl[t].word);
      chk({tbl[t].name, "_stuck"}, os[os.size()-1], tbl[t].stuck);
    end

    // sticky health flag
    rst(); clr();
    for (int i = 0; i < 8; i++) begin sq.push_back(0); eq.push_back(1); rq.push_back(1); end
    run_stream();
    for (int i = 0; i < 10; i++) cyc(1'($urandom), 1, 1, 0);
    chk("stuck_hold_en", STUCK_O, 1);
    for (int i = 0; i < 3; i++) cyc(1'($urandom), 0, 1, 0);
    chk("stuck_hold_dis", STUCK_O, 1);
    rst();

    // stall drops bits; next word starts empty
    clr(); add_pairs(1, 0, 26, 0);
    foreach (rq[k]) rq[k] = (k >= 36);
    run_stream();
    chk("stall_v35", ov[35], 1);
    chk("stall_w35", ow[35], 8'hFF);
    chk("stall_v36", ov[36], 0);
    chk("stall_v50", ov[50], 0);
    chk("stall_v51", ov[51], 1);

    // handshake coinciding with an emitted bit
    rst(); clr();
    add_pairs(1, 0, 9, 1); add_pairs(0, 1, 7, 1); add_pairs(0, 0, 1, 1);
    foreach (rq[k]) rq[k] = (k >= 17);
    run_stream();
    chk("coin_v16", ov[16], 1);
    chk("coin_v17", ov[17], 0);
    chk("coin_v30", ov[30], 0);
    chk("coin_v31", ov[31], 1);
    chk("coin_w31", ow[31], 8'h80);

    // reset mid-word, then reset while a word is pending
    rst(); clr(); add_pairs(0, 1, 4, 1); run_stream();
    rst(); clr(); add_pairs(0, 1, 8, 1); run_stream();
    chk("rst_mid_first", first_valid(), 16);
    rst(); clr(); add_pairs(1, 0, 9, 0); run_stream();
    chk("pend_valid", ov[ov.size()-1], 1);
    rst(); clr(); add_pairs(1, 0, 8, 1); run_stream();
    chk("rst_pend_first", first_valid(), 16);

    // EN=0 between the two bits of a pair
    rst(); clr();
    sq = '{1, 0, 0, 1}; eq = '{1, 0, 1, 1}; rq = '{1, 1, 1, 1};
    add_pairs(1, 0, 7, 1);
    run_stream();
    chk("engap_first", first_valid(), 18);
    chk("engap_word", ow[17], 8'h7F);

    // randomized traffic against the model
    rst(); pr = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) pr = ~pr;
      cyc(pr, $urandom_range(0, 15) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 399) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
